// File: rtl/vc_flit_queue_if.sv
// Flit type package and the push/pop port bundle of vc_flit_queue.
// The queue takes the slave modport; the producer/consumer side takes master.
package types;
  typedef struct packed {
    logic [7:0]  src_id;
    logic [7:0]  dst_id;
    logic [15:0] payload;
  } flit_t;
endpackage

interface vc_flit_queue_if #(
  parameter int unsigned NUM_VC = 4,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  types::flit_t              pushed_flit;
  logic [VC_W-1:0]           pushed_vc;
  logic                      pushed_flit_valid;
  logic                      pushed_flit_ready;
  logic [NUM_VC-1:0]         vc_ready;
  logic                      poped_flit_ready;
  logic                      poped_flit_valid;
  types::flit_t              poped_flit;
  logic [VC_W-1:0]           poped_vc;
  logic [NUM_VC*CNT_W-1:0]   vc_count;

  modport master (
    output pushed_flit, pushed_vc, pushed_flit_valid, poped_flit_ready,
    input  pushed_flit_ready, vc_ready, poped_flit_valid, poped_flit, poped_vc, vc_count
  );

  modport slave (
    input  pushed_flit, pushed_vc, pushed_flit_valid, poped_flit_ready,
    output pushed_flit_ready, vc_ready, poped_flit_valid, poped_flit, poped_vc, vc_count
  );
endinterface

// File: rtl/vc_flit_queue.sv
// Multi-VC flit buffer: NUM_VC FIFOs drained through one port by a locking round-robin arbiter.
// Define VC_FLIT_QUEUE_CREDIT_EN to add the registered credit_valid/credit_vc return.
module vc_flit_queue #(
  parameter int unsigned NUM_VC = 4,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  vc_flit_queue_if.slave  q
`ifdef VC_FLIT_QUEUE_CREDIT_EN
  ,
  output logic            credit_valid,
  output logic [VC_W-1:0] credit_vc
`endif
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] Full = CNT_W'(DEPTH);

  typedef enum logic [0:0] {StFree, StLocked} arb_state_e;

  types::flit_t      mem_q [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0]  cnt_q [NUM_VC];
  logic [CNT_W-1:0]  cnt_d [NUM_VC];
  logic [VC_W-1:0]   rr_q, rr_d;
  logic [VC_W-1:0]   lock_vc_q, lock_vc_d;
  arb_state_e        state_q, state_d;

  logic [NUM_VC-1:0] vc_rdy;
  logic [NUM_VC-1:0] push_sel;
  logic [NUM_VC-1:0] pop_sel;
  logic [VC_W-1:0]   free_vc;
  logic [VC_W-1:0]   grant;
  logic              any_busy;
  logic              offer;
  logic              pop_fire;

  // Readiness looks only at registered counts, so a full VC refuses even while popped.
  always_comb begin
    vc_rdy              = '0;
    push_sel            = '0;
    q.pushed_flit_ready = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      vc_rdy[i] = (cnt_q[i] != Full);
      if (q.pushed_vc == VC_W'(i)) begin
        q.pushed_flit_ready = vc_rdy[i];
        push_sel[i]         = q.pushed_flit_valid && vc_rdy[i];
      end
    end
  end

  assign q.vc_ready = vc_rdy;

  always_comb begin
    q.vc_count = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      q.vc_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  // Round-robin search starting at rr_q; only used while no grant is locked.
  always_comb begin
    free_vc  = '0;
    any_busy = 1'b0;
    for (int k = 0; k < NUM_VC; k++) begin
      if (!any_busy && cnt_q[(int'(rr_q) + k) % int'(NUM_VC)] != '0) begin
        any_busy = 1'b1;
        free_vc  = VC_W'((int'(rr_q) + k) % int'(NUM_VC));
      end
    end
  end

  always_comb begin
    grant              = (state_q == StLocked) ? lock_vc_q : free_vc;
    offer              = (state_q == StLocked) || any_busy;
    q.poped_flit_valid = offer;
    q.poped_vc         = grant;
    q.poped_flit       = mem_q[grant][rd_ptr_q[grant]];
    pop_fire           = offer && q.poped_flit_ready;
  end

  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    rr_d      = rr_q;
    unique case (state_q)
      StFree: begin
        if (offer && !q.poped_flit_ready) begin
          state_d   = StLocked;
          lock_vc_d = grant;
        end
      end
      StLocked: begin
        if (q.poped_flit_ready) state_d = StFree;
      end
      default: state_d = StFree;
    endcase
    if (pop_fire) rr_d = VC_W'((int'(grant) + 1) % int'(NUM_VC));
  end

  always_comb begin
    pop_sel = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      pop_sel[i]  = pop_fire && (grant == VC_W'(i));
      wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push_sel[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop_sel[i]);
      cnt_d[i]    = cnt_q[i] + CNT_W'(push_sel[i]) - CNT_W'(pop_sel[i]);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_VC; i++) begin
      if (push_sel[i]) mem_q[i][wr_ptr_q[i]] <= q.pushed_flit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_q      <= '0;
      lock_vc_q <= '0;
      state_q   <= StFree;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rr_q      <= rr_d;
      lock_vc_q <= lock_vc_d;
      state_q   <= state_d;
    end
  end

`ifdef VC_FLIT_QUEUE_CREDIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_valid <= 1'b0;
      credit_vc    <= '0;
    end else begin
      credit_valid <= pop_fire;
      if (pop_fire) credit_vc <= grant;
    end
  end
`endif
endmodule

// File: tb/tb_vc_flit_queue.sv
// Self-checking bench for vc_flit_queue: directed plan with literal expectations plus random
// traffic, all checked every cycle against a queue-based model of the buffer and arbiter.
module tb_vc_flit_queue;
  import types::*;

  localparam int unsigned NUM_VC = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned VC_W   = 2;
  localparam int unsigned CNT_W  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vc_flit_queue_if #(.NUM_VC(NUM_VC), .DEPTH(DEPTH)) qif ();

`ifdef VC_FLIT_QUEUE_CREDIT_EN
  logic            credit_valid;
  logic [VC_W-1:0] credit_vc;
`endif

  vc_flit_queue #(.NUM_VC(NUM_VC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (qif)
`ifdef VC_FLIT_QUEUE_CREDIT_EN
    ,
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: one plain queue per VC, a round-robin start index and a held grant.
  flit_t mq [NUM_VC][$];
  int    rr;
  bit    held;
  int    held_vc;
  bit    exp_cv;
  int    exp_cvc;

  function automatic void model_reset();
    for (int i = 0; i < NUM_VC; i++) mq[i].delete();
    rr      = 0;
    held    = 0;
    held_vc = 0;
    exp_cv  = 0;
    exp_cvc = 0;
  endfunction

  function automatic void model_offer(output bit v, output int g);
    v = 0;
    g = 0;
    if (held) begin
      v = 1;
      g = held_vc;
      return;
    end
    for (int k = 0; k < NUM_VC; k++) begin
      if (mq[(rr + k) % NUM_VC].size() != 0) begin
        v = 1;
        g = (rr + k) % NUM_VC;
        return;
      end
    end
  endfunction

  function automatic void model_edge();
    bit v;
    int g;
    int pv;
    bit pop;
    bit push;
    model_offer(v, g);
    pv   = int'(qif.pushed_vc);
    pop  = v && qif.poped_flit_ready;
    push = qif.pushed_flit_valid && pv < NUM_VC && mq[pv].size() < DEPTH;
    exp_cv = pop;
    if (pop) begin
      exp_cvc = g;
      void'(mq[g].pop_front());
      rr   = (g + 1) % NUM_VC;
      held = 0;
    end else if (v) begin
      held    = 1;
      held_vc = g;
    end
    if (push) mq[pv].push_back(qif.pushed_flit);
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    bit v;
    int g;
    int pv;
    model_offer(v, g);
    chk("poped_flit_valid", qif.poped_flit_valid, v);
    if (v) begin
      chk("poped_vc", qif.poped_vc, g);
      chk("poped_flit", qif.poped_flit, mq[g][0]);
    end
    for (int i = 0; i < NUM_VC; i++) begin
      chk("vc_count", qif.vc_count[i*CNT_W +: CNT_W], mq[i].size());
      chk("vc_ready", qif.vc_ready[i], mq[i].size() < DEPTH);
    end
    pv = int'(qif.pushed_vc);
    chk("pushed_flit_ready", qif.pushed_flit_ready, pv < NUM_VC && mq[pv].size() < DEPTH);
`ifdef VC_FLIT_QUEUE_CREDIT_EN
    chk("credit_valid", credit_valid, exp_cv);
    if (exp_cv) chk("credit_vc", credit_vc, exp_cvc);
`endif
  end

  function automatic flit_t mk(logic [7:0] src);
    flit_t f;
    f.src_id  = src;
    f.dst_id  = src ^ 8'hA5;
    f.payload = {src, ~src};
    return f;
  endfunction

  task automatic drive(input int pv, input flit_t f, input bit vld, input bit rdy);
    qif.pushed_vc         = VC_W'(pv);
    qif.pushed_flit       = f;
    qif.pushed_flit_valid = vld;
    qif.poped_flit_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic cyc(input int pv, input flit_t f, input bit vld, input bit rdy);
    drive(pv, f, vld, rdy);
    tick();
  endtask

  task automatic pop_one();
    cyc(0, mk(8'h00), 0, 1);
  endtask

  initial begin
    model_reset();
    drive(0, mk(8'h00), 0, 0);
    #1;
    chk("rst_valid", qif.poped_flit_valid, 0);
    chk("rst_poped_vc", qif.poped_vc, 0);
    chk("rst_vc_count", qif.vc_count, 0);
    chk("rst_vc_ready", qif.vc_ready, 4'hF);
    chk("rst_push_ready", qif.pushed_flit_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single flit on VC2, one-cycle latency, then pop.
    cyc(2, mk(8'h01), 1, 0);
    chk("vc2_valid", qif.poped_flit_valid, 1);
    chk("vc2_poped_vc", qif.poped_vc, 2);
    chk("vc2_src", qif.poped_flit.src_id, 8'h01);
    chk("vc2_count", qif.vc_count, 12'h040);
    pop_one();
    chk("vc2_empty_valid", qif.poped_flit_valid, 0);
    chk("vc2_empty_count", qif.vc_count, 0);
`ifdef VC_FLIT_QUEUE_CREDIT_EN
    chk("credit_pulse", credit_valid, 1);
    chk("credit_vc2", credit_vc, 2);
`endif

    // Fill VC0 to DEPTH, refuse the extra push, drain in order; twice to exercise wrap.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) cyc(0, mk(8'(8'h10 + i)), 1, 0);
      chk("fill_count", qif.vc_count[CNT_W-1:0], 4);
      chk("fill_vc_ready0", qif.vc_ready[0], 0);
      drive(0, mk(8'h14), 1, 0);
      #1 chk("full_push_ready", qif.pushed_flit_ready, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
        chk("drain_src", qif.poped_flit.src_id, 8'(8'h10 + i));
        pop_one();
      end
      chk("drain_valid", qif.poped_flit_valid, 0);
    end

    // One flit per VC, drained in VC order.
    for (int i = 0; i < 4; i++) cyc(i, mk(8'(8'h20 + i)), 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("rr_vc", qif.poped_vc, i);
      chk("rr_src", qif.poped_flit.src_id, 8'(8'h20 + i));
      pop_one();
    end

    // VC0 and VC1 both busy: grants alternate.
    for (int i = 0; i < 4; i++) cyc(i % 2, mk(8'(8'h30 + i)), 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("alt_vc", qif.poped_vc, i % 2);
      chk("alt_src", qif.poped_flit.src_id, 8'(8'h30 + i));
      pop_one();
    end

    // Grant lock on VC3 survives a push to VC0.
    cyc(3, mk(8'h40), 1, 0);
    chk("lock_vc3", qif.poped_vc, 3);
    cyc(0, mk(8'h41), 1, 0);
    chk("lock_hold_vc", qif.poped_vc, 3);
    chk("lock_hold_src", qif.poped_flit.src_id, 8'h40);
    pop_one();
    chk("after_lock_vc", qif.poped_vc, 0);
    chk("after_lock_src", qif.poped_flit.src_id, 8'h41);
    pop_one();

    // Full VC1 refuses a push even while being popped.
    for (int i = 0; i < 4; i++) cyc(1, mk(8'(8'h50 + i)), 1, 0);
    drive(1, mk(8'h54), 1, 1);
    #1 chk("full_pop_push_ready", qif.pushed_flit_ready, 0);
    tick();
    chk("full_pop_count", qif.vc_count[CNT_W +: CNT_W], 3);
    chk("full_pop_src", qif.poped_flit.src_id, 8'h51);
    repeat (3) pop_one();

    // Simultaneous push and pop on VC0 at count 2.
    cyc(0, mk(8'h60), 1, 0);
    cyc(0, mk(8'h61), 1, 0);
    cyc(0, mk(8'h62), 1, 1);
    chk("pushpop_count", qif.vc_count[CNT_W-1:0], 2);
    chk("pushpop_src", qif.poped_flit.src_id, 8'h61);
    repeat (2) pop_one();

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) cyc(i, mk(8'(8'h70 + i)), 1, 0);
    drive(3, mk(8'h73), 1, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", qif.poped_flit_valid, 0);
    chk("midrst_count", qif.vc_count, 0);
    model_reset();
    drive(0, mk(8'h00), 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic: a congested phase then a free-flowing one.
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 1500; n++) begin
        cyc($urandom_range(0, NUM_VC - 1), flit_t'($urandom), $urandom_range(0, 3) != 0,
            (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      end
    end
    repeat (2 * NUM_VC * DEPTH) pop_one();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
